// File: rtl/gain_ramp_ctrl.sv
// Gain sequencer for the FSK/PSK scaler: clamps written targets and ramps each
// channel's gain toward its target in bounded steps on a shared prescaled tick.
module gain_ramp_ctrl #(
  parameter int GAIN_W   = 9,
  parameter int MAX_GAIN = 102,
  parameter int STEP     = 1,
  parameter int RATE_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_sel,
  input  logic [GAIN_W-1:0] wr_gain,
  output logic [GAIN_W-1:0] gain_fsk,
  output logic [GAIN_W-1:0] gain_psk,
  output logic [1:0]        ramp_busy,
  output logic [1:0]        ramp_done,
  output logic              clamp_hit
);

  // state  | meaning
  // S_IDLE | gain equals target, waiting for a write
  // S_RAMP | gain moves toward target by up to STEP on each tick
  typedef enum logic {S_IDLE, S_RAMP} state_t;

  localparam int                CNT_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RATE_DIV - 1);
  localparam logic [GAIN_W-1:0] MAX_G    = GAIN_W'(MAX_GAIN);
  localparam logic [GAIN_W-1:0] STEP_G   = GAIN_W'(STEP);

  logic [CNT_W-1:0]  cnt_q;
  logic              tick;
  logic              accept;
  logic              wr_over;
  logic [GAIN_W-1:0] wr_clamped;

  state_t            state_q [2];
  state_t            state_d [2];
  logic [GAIN_W-1:0] gain_q  [2];
  logic [GAIN_W-1:0] gain_d  [2];
  logic [GAIN_W-1:0] tgt_q   [2];
  logic [GAIN_W-1:0] tgt_d   [2];
  logic [GAIN_W-1:0] diff    [2];
  logic [GAIN_W-1:0] mag     [2];
  logic              hit     [2];
  logic              done_q  [2];
  logic              done_d  [2];

  assign tick       = (cnt_q == CNT_LAST);
  assign accept     = wr_valid && wr_ready;
  assign wr_over    = (wr_gain > MAX_G);
  assign wr_clamped = wr_over ? MAX_G : wr_gain;

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      gain_d[ch]  = gain_q[ch];
      tgt_d[ch]   = tgt_q[ch];
      done_d[ch]  = 1'b0;
      hit[ch]     = accept && (int'(wr_sel) == ch);
      diff[ch]    = (gain_q[ch] > tgt_q[ch]) ? (gain_q[ch] - tgt_q[ch]) : (tgt_q[ch] - gain_q[ch]);
      mag[ch]     = (diff[ch] < STEP_G) ? diff[ch] : STEP_G;
      case (state_q[ch])
        S_IDLE: begin
          if (hit[ch]) begin
            tgt_d[ch] = wr_clamped;
            if (wr_clamped != gain_q[ch]) state_d[ch] = S_RAMP;
            else                          done_d[ch]  = 1'b1;
          end
        end
        S_RAMP: begin
          // The step on a tick uses the target held before any same-edge write.
          if (tick) begin
            gain_d[ch] = (gain_q[ch] > tgt_q[ch]) ? (gain_q[ch] - mag[ch]) : (gain_q[ch] + mag[ch]);
          end
          if (hit[ch]) tgt_d[ch] = wr_clamped;
          if (tick && (gain_d[ch] == tgt_d[ch])) begin
            state_d[ch] = S_IDLE;
            done_d[ch]  = 1'b1;
          end
        end
        default: state_d[ch] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_ready  <= 1'b0;
      clamp_hit <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= S_IDLE;
        gain_q[ch]  <= '0;
        tgt_q[ch]   <= '0;
        done_q[ch]  <= 1'b0;
      end
    end else begin
      cnt_q     <= tick ? '0 : (cnt_q + CNT_W'(1));
      wr_ready  <= !accept;
      clamp_hit <= accept && wr_over;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        gain_q[ch]  <= gain_d[ch];
        tgt_q[ch]   <= tgt_d[ch];
        done_q[ch]  <= done_d[ch];
      end
    end
  end

  assign gain_fsk  = gain_q[0];
  assign gain_psk  = gain_q[1];
  assign ramp_busy = {state_q[1] == S_RAMP, state_q[0] == S_RAMP};
  assign ramp_done = {done_q[1], done_q[0]};

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Bench for gain_ramp_ctrl: two instances (STEP=1/RATE_DIV=4 and STEP=4/RATE_DIV=3)
// compared against an arithmetic reference model, plus directed scenario checks.
module tb_gain_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v   [2];
  logic       s   [2];
  logic [8:0] gi  [2];
  logic       rdy [2];
  logic [8:0] gf  [2];
  logic [8:0] gp  [2];
  logic [1:0] bsy [2];
  logic [1:0] dn  [2];
  logic       clh [2];

  int checks = 0;
  int errors = 0;

  int m_gain [2][2];
  int m_tgt  [2][2];
  bit m_busy [2][2];
  bit m_done [2][2];
  bit m_ready[2];
  bit m_clamp[2];
  int m_cnt  [2];

  always #5 clk = ~clk;

  gain_ramp_ctrl #(.GAIN_W(9), .MAX_GAIN(102), .STEP(1), .RATE_DIV(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(v[0]), .wr_ready(rdy[0]), .wr_sel(s[0]), .wr_gain(gi[0]),
    .gain_fsk(gf[0]), .gain_psk(gp[0]), .ramp_busy(bsy[0]), .ramp_done(dn[0]), .clamp_hit(clh[0])
  );

  gain_ramp_ctrl #(.GAIN_W(9), .MAX_GAIN(102), .STEP(4), .RATE_DIV(3)) dut4 (
    .clk(clk), .rst(rst), .wr_valid(v[1]), .wr_ready(rdy[1]), .wr_sel(s[1]), .wr_gain(gi[1]),
    .gain_fsk(gf[1]), .gain_psk(gp[1]), .ramp_busy(bsy[1]), .ramp_done(dn[1]), .clamp_hit(clh[1])
  );

  function automatic logic [23:0] dvec(int u);
    return {gf[u], gp[u], bsy[u], dn[u], clh[u], rdy[u]};
  endfunction

  function automatic logic [23:0] mvec(int u);
    return {9'(m_gain[u][0]), 9'(m_gain[u][1]), m_busy[u][1], m_busy[u][0],
            m_done[u][1], m_done[u][0], m_clamp[u], m_ready[u]};
  endfunction

  // Reference: gain moves toward target by at most step per tick, never past it.
  task automatic model_update(int u);
    int step, div, newt, d, mv;
    bit tk, acc, hit;
    step = (u == 0) ? 1 : 4;
    div  = (u == 0) ? 4 : 3;
    if (rst) begin
      m_cnt[u] = 0; m_ready[u] = 0; m_clamp[u] = 0;
      for (int ch = 0; ch < 2; ch++) begin
        m_gain[u][ch] = 0; m_tgt[u][ch] = 0; m_busy[u][ch] = 0; m_done[u][ch] = 0;
      end
    end else begin
      tk   = (m_cnt[u] == div - 1);
      acc  = v[u] && m_ready[u];
      newt = (int'(gi[u]) > 102) ? 102 : int'(gi[u]);
      m_cnt[u]   = tk ? 0 : m_cnt[u] + 1;
      m_clamp[u] = acc && (int'(gi[u]) > 102);
      m_ready[u] = !acc;
      for (int ch = 0; ch < 2; ch++) begin
        hit = acc && (int'(s[u]) == ch);
        m_done[u][ch] = 0;
        if (m_busy[u][ch]) begin
          if (tk) begin
            d  = m_tgt[u][ch] - m_gain[u][ch];
            mv = (d >= 0) ? ((d < step) ? d : step) : ((-d < step) ? d : -step);
            m_gain[u][ch] += mv;
          end
          if (hit) m_tgt[u][ch] = newt;
          if (tk && m_gain[u][ch] == m_tgt[u][ch]) begin
            m_busy[u][ch] = 0; m_done[u][ch] = 1;
          end
        end else if (hit) begin
          m_tgt[u][ch] = newt;
          if (newt != m_gain[u][ch]) m_busy[u][ch] = 1;
          else                       m_done[u][ch] = 1;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update(0);
    model_update(1);
    @(negedge clk);
  endtask

  task automatic wr(int u, int sel, int g);
    while (!m_ready[u]) cyc();
    v[u] = 1'b1; s[u] = (sel != 0); gi[u] = 9'(g);
    cyc();
    v[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    checks++; if (dvec(0) !== 24'h0) begin errors++; $display("FAIL reset_dut: got %h want %h", dvec(0), 24'h0); end
    checks++; if (dvec(1) !== 24'h0) begin errors++; $display("FAIL reset_dut4: got %h want %h", dvec(1), 24'h0); end
    rst = 1'b0;
    cyc();
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy[0]); end
    checks++; if (dvec(1) !== mvec(1)) begin errors++; $display("FAIL reset_release: got %h want %h", dvec(1), mvec(1)); end
  endtask

  task automatic test_ramp_up();
    int pulses = 0, chg = 0, last = -1, prev, n = 0;
    wr(0, 0, 100);
    checks++; if (bsy[0] !== 2'b01) begin errors++; $display("FAIL ramp_up_busy: got %b want 01", bsy[0]); end
    prev = int'(gf[0]);
    while ((m_busy[0][0] || m_done[0][0]) && n < 600) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL ramp_up_model cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
      if (dn[0][0]) pulses++;
      if (int'(gf[0]) != prev) begin
        checks++;
        if (int'(gf[0]) != prev + 1 || (last >= 0 && n - last != 4)) begin
          errors++; $display("FAIL ramp_up_step cyc %0d: got %0d after %0d cycles want %0d after 4", n, gf[0], n - last, prev + 1);
        end
        last = n; chg++; prev = int'(gf[0]);
      end
    end
    checks++; if (n >= 600) begin errors++; $display("FAIL ramp_up_timeout: got %0d cycles want < 600", n); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ramp_up_done: got %0d pulses want 1", pulses); end
    checks++; if (chg != 100) begin errors++; $display("FAIL ramp_up_steps: got %0d want 100", chg); end
    checks++; if (gf[0] !== 9'd100) begin errors++; $display("FAIL ramp_up_final: got %0d want 100", gf[0]); end
    checks++; if (gp[0] !== 9'd0) begin errors++; $display("FAIL ramp_up_psk: got %0d want 0", gp[0]); end
  endtask

  task automatic test_clamp();
    int pulses = 0, maxg = 0, n = 0;
    wr(0, 1, 300);
    checks++; if (clh[0] !== 1'b1) begin errors++; $display("FAIL clamp_hit: got %b want 1", clh[0]); end
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL clamp_ready: got %b want 0", rdy[0]); end
    while ((m_busy[0][1] || m_done[0][1]) && n < 600) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL clamp_model cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
      if (dn[0][1]) pulses++;
      if (int'(gp[0]) > maxg) maxg = int'(gp[0]);
    end
    checks++; if (maxg != 102) begin errors++; $display("FAIL clamp_max: got %0d want 102", maxg); end
    checks++; if (gp[0] !== 9'd102) begin errors++; $display("FAIL clamp_final: got %0d want 102", gp[0]); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL clamp_done: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_step4();
    int seq[$];
    int pulses = 0, prev, n = 0, got0, got1;
    wr(1, 0, 10);
    while ((m_busy[1][0] || m_done[1][0]) && n < 100) begin
      cyc(); n++;
      checks++; if (dvec(1) !== mvec(1)) begin errors++; $display("FAIL step4_up cyc %0d: got %h want %h", n, dvec(1), mvec(1)); end
    end
    checks++; if (gf[1] !== 9'd10) begin errors++; $display("FAIL step4_start: got %0d want 10", gf[1]); end
    wr(1, 0, 3);
    prev = int'(gf[1]); n = 0;
    while ((m_busy[1][0] || m_done[1][0]) && n < 100) begin
      cyc(); n++;
      checks++; if (dvec(1) !== mvec(1)) begin errors++; $display("FAIL step4_down cyc %0d: got %h want %h", n, dvec(1), mvec(1)); end
      if (dn[1][0]) pulses++;
      if (int'(gf[1]) != prev) begin seq.push_back(int'(gf[1])); prev = int'(gf[1]); end
    end
    got0 = (seq.size() > 0) ? seq[0] : -1;
    got1 = (seq.size() > 1) ? seq[1] : -1;
    checks++;
    if (seq.size() != 2 || got0 != 6 || got1 != 3) begin
      errors++; $display("FAIL step4_seq: got %0d values %0d,%0d want 2 values 6,3", seq.size(), got0, got1);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step4_done: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_retarget();
    int pulses = 0, maxg, prev, n = 0;
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    wr(0, 0, 50);
    while (m_gain[0][0] != 20 && n < 300) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL retarget_up cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
      if (dn[0][0]) pulses++;
    end
    wr(0, 0, 5);
    maxg = int'(gf[0]); prev = int'(gf[0]); n = 0;
    while ((m_busy[0][0] || m_done[0][0]) && n < 300) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL retarget_down cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
      if (dn[0][0]) pulses++;
      if (int'(gf[0]) > maxg) maxg = int'(gf[0]);
      if (int'(gf[0]) != prev) begin
        checks++;
        if (int'(gf[0]) != prev - 1) begin errors++; $display("FAIL retarget_jump: got %0d want %0d", gf[0], prev - 1); end
        prev = int'(gf[0]);
      end
    end
    checks++; if (maxg != 20) begin errors++; $display("FAIL retarget_peak: got %0d want 20", maxg); end
    checks++; if (gf[0] !== 9'd5) begin errors++; $display("FAIL retarget_final: got %0d want 5", gf[0]); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL retarget_done: got %0d pulses want 1", pulses); end
  endtask

  task automatic test_back_to_back();
    int d0 = 0, d1 = 0, both = 0, pf, pp, n = 0;
    wr(0, 0, 30);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_a: got %b want 0", rdy[0]); end
    cyc();
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", rdy[0]); end
    wr(0, 1, 40);
    checks++; if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_b: got %b want 0", rdy[0]); end
    pf = int'(gf[0]); pp = int'(gp[0]);
    while ((m_busy[0][0] || m_busy[0][1] || m_done[0][0] || m_done[0][1]) && n < 600) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL b2b_model cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
      if (dn[0][0]) d0++;
      if (dn[0][1]) d1++;
      if (int'(gf[0]) != pf && int'(gp[0]) != pp) both++;
      pf = int'(gf[0]); pp = int'(gp[0]);
    end
    checks++; if (d0 != 1 || d1 != 1) begin errors++; $display("FAIL b2b_done: got %0d/%0d pulses want 1/1", d0, d1); end
    checks++; if (both < 20) begin errors++; $display("FAIL b2b_shared_ticks: got %0d want >= 20", both); end
    checks++; if (gf[0] !== 9'd30 || gp[0] !== 9'd40) begin errors++; $display("FAIL b2b_final: got %0d/%0d want 30/40", gf[0], gp[0]); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    wr(0, 0, 80);
    while (m_gain[0][0] != 37 && n < 300) begin
      cyc(); n++;
      checks++; if (dvec(0) !== mvec(0)) begin errors++; $display("FAIL rstmid_up cyc %0d: got %h want %h", n, dvec(0), mvec(0)); end
    end
    checks++; if (gf[0] !== 9'd37) begin errors++; $display("FAIL rstmid_at37: got %0d want 37", gf[0]); end
    rst = 1'b1; cyc();
    checks++; if (dvec(0) !== 24'h0) begin errors++; $display("FAIL rstmid_clear: got %h want %h", dvec(0), 24'h0); end
    rst = 1'b0; cyc();
    checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", rdy[0]); end
    for (int i = 0; i < 20; i++) begin
      cyc();
      checks++; if (dn[0] !== 2'b00 || dvec(0) !== mvec(0)) begin errors++; $display("FAIL rstmid_quiet cyc %0d: got %h want %h", i, dvec(0), mvec(0)); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      for (int u = 0; u < 2; u++) begin
        v[u]  = ($urandom_range(0, 9) == 0);
        s[u]  = 1'($urandom_range(0, 1));
        gi[u] = 9'($urandom_range(0, 1) ? $urandom_range(0, 110) : $urandom_range(0, 511));
      end
      rst = ($urandom_range(0, 1499) == 0);
      cyc();
      for (int u = 0; u < 2; u++) begin
        checks++; if (dvec(u) !== mvec(u)) begin errors++; $display("FAIL random u%0d cyc %0d: got %h want %h", u, i, dvec(u), mvec(u)); end
      end
    end
    rst = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      v[u] = 1'b0; s[u] = 1'b0; gi[u] = '0;
    end
    test_reset();
    test_ramp_up();
    test_clamp();
    test_step4();
    test_retarget();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
